// File: rtl/step_generator.sv
// -----------------------------------------------------------------------------
// step_generator
//
// Step/dir pulse transmitter. Accepts move commands (direction, step count,
// step period) over a valid/ready handshake and produces the step/dir waveform
// for the H-bridge driver. Every command first holds dir stable for DIR_SETUP
// cycles, then emits step pulses of PULSE_W cycles high on a fixed period.
// Periods shorter than PULSE_W+1 are stretched so the low time is never zero.
//
// Parameters
//   CNT_W     width of the per-command step count
//   PER_W     width of the step period (clk cycles, rising edge to rising edge)
//   DIR_SETUP cycles dir is held before the first step of a command (>= 1)
//   PULSE_W   step high time in cycles (>= 1)
//
// Ports
//   clk        sole clock
//   reset      asynchronous, active-high reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (IDLE only, low while reset is high)
//   cmd_dir    command direction, 1 = forward
//   cmd_steps  number of steps, 0 is a legal empty move
//   cmd_period step period in clk cycles
//   abort      stop the current move at the next safe point
//   step       step pulse to the driver
//   dir        direction to the driver, changes only on command acceptance
//   busy       move in progress (SETUP/HIGH/LOW)
//   done       one-cycle pulse at the end of every accepted move
//   position   signed absolute step position
//
// Build option
//   STEPGEN_POSITION_EN  when defined, position counts step rising edges
//                        (+1 forward, -1 reverse, two's complement wrap);
//                        when undefined, no counter exists and position = 0.
// -----------------------------------------------------------------------------
module step_generator #(
  parameter int CNT_W     = 32,
  parameter int PER_W     = 16,
  parameter int DIR_SETUP = 4,
  parameter int PULSE_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [31:0]      position
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The phase counter shares one width for the setup hold, the high time and
  // the full period; DIR_SETUP and PULSE_W+1 must fit in PER_W bits.
  localparam logic [PER_W-1:0] MIN_PER    = PER_W'(PULSE_W + 1);
  localparam logic [PER_W-1:0] SETUP_LAST = PER_W'(DIR_SETUP);
  localparam logic [PER_W-1:0] HIGH_LAST  = PER_W'(PULSE_W);

  // Stretch short periods so a pulse always gets at least one low cycle.
  function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
    return (p < MIN_PER) ? MIN_PER : p;
  endfunction

  // Two's complement step of the position counter; wraps naturally.
  function automatic logic signed [31:0] step_pos(input logic signed [31:0] p,
                                                  input logic              fwd);
    return fwd ? (p + 32'sd1) : (p - 32'sd1);
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              enter_high;
  logic              abort_pend;
  logic [CNT_W-1:0]  remaining;
  logic [PER_W-1:0]  per;
  logic [PER_W-1:0]  ph;

  assign cmd_ready = (state == IDLE) & ~reset;

  // ph counts cycles since the last phase start: 1 on the first SETUP cycle,
  // 1 on the first HIGH cycle, and keeps counting through LOW so that the
  // rising-edge-to-rising-edge period is simply ph == per.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_high = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (cmd_steps == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (ph == SETUP_LAST) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        // An abort seen anywhere in the pulse only takes effect once the full
        // high time has elapsed.
        if (ph == HIGH_LAST) begin
          state_nxt = (abort | abort_pend) ? DONE : LOW;
        end
      end
      LOW: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (ph == per) begin
          state_nxt = (remaining == '0) ? DONE : HIGH;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    enter_high = (state_nxt == HIGH) && (state != HIGH);
  end

  // Control registers: state, registered outputs, latched direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= (state_nxt == HIGH);
      busy  <= (state_nxt == SETUP) || (state_nxt == HIGH) || (state_nxt == LOW);
      done  <= (state_nxt == DONE);
      if (accept) begin
        dir <= cmd_dir;
      end
      if (accept) begin
        abort_pend <= 1'b0;
      end else if ((state == HIGH) && abort) begin
        abort_pend <= 1'b1;
      end
    end
  end

  // Move datapath: loaded on acceptance, only meaningful while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      remaining <= cmd_steps;
      per       <= clamp_period(cmd_period);
      ph        <= PER_W'(1);
    end else if (enter_high) begin
      remaining <= remaining - CNT_W'(1);
      ph        <= PER_W'(1);
    end else begin
      ph <= ph + PER_W'(1);
    end
  end

`ifdef STEPGEN_POSITION_EN
  logic signed [31:0] pos_q;

  // Counted on the same edge that raises step, so position and step agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else if (enter_high) begin
      pos_q <= step_pos(pos_q, dir);
    end
  end

  assign position = pos_q;
`else
  assign position = '0;
`endif

endmodule
